wb_master_mux: RTL and testbench
================================

// Module: wb_master_mux
// PURPOSE
//  Downstream consumer of the 5-way grant arbiter for the ss_adma Wishbone masters.
//  Latches the one-hot gnt[4:0] into an ownership register when the bus is idle.
//  Routes the owning master's cycle onto the single shared Wishbone master port and
//  steers ack/err back to that master only. A watchdog aborts cycles whose slave never
//  responds, so a hung SG/memory access cannot lock out the other four masters.
// PARAMETERS
//  AW   32   address width, per master
//  DW   32   data width; SEL width = DW/8
//  TMO  255  cycles with stb high and no ack/err before abort; 0 disables watchdog
// PORTS
//  wb_clk_i   in   1        system clock
//  wb_rst_i   in   1        reset, asynchronous, active-high
//  gnt        in   5        grant from arbiter, expected one-hot (0 = none)
//  m_cyc_i    in   5        per-master cyc, bit i = master i
//  m_stb_i    in   5        per-master stb
//  m_we_i     in   5        per-master we
//  m_sel_i    in   5*DW/8   per-master sel, master i at [i*DW/8 +: DW/8]
//  m_adr_i    in   5*AW     per-master address, master i at [i*AW +: AW]
//  m_dat_i    in   5*DW     per-master write data
//  m_ack_o    out  5        ack to owner only
//  m_err_o    out  5        err to owner only (slave err or watchdog abort)
//  m_dat_o    out  DW       read data, broadcast to all masters
//  wbm_cyc_o  out  1        shared-bus cyc
//  wbm_stb_o  out  1        shared-bus stb
//  wbm_we_o   out  1        shared-bus we
//  wbm_sel_o  out  DW/8     shared-bus sel
//  wbm_adr_o  out  AW       shared-bus address
//  wbm_dat_o  out  DW       shared-bus write data
//  wbm_dat_i  in   DW       shared-bus read data
//  wbm_ack_i  in   1        shared-bus ack
//  wbm_err_i  in   1        shared-bus err
//  owner_o    out  5        registered one-hot current owner (0 when idle)
//  tmo_o      out  1        one-cycle pulse on a watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE, owner_o=0, watchdog count=0, tmo_o=0. All wbm_* outputs and
//   m_ack_o/m_err_o are 0. Reset asserted mid-cycle drops wbm_cyc_o at once (async).
//  FSM states IDLE, OWN, ABORT; encodings are taken from the package.
//  IDLE:
//   - sel = gnt & m_cyc_i. If gnt has several bits set, the lowest index wins.
//   - sel!=0 -> owner_o <= that bit, go to OWN. sel==0 -> stay IDLE.
//   - wbm_cyc_o is first asserted in the cycle after the grant is sampled (1-cycle latency).
//  OWN:
//   - wbm_cyc/stb/we/sel/adr/dat_o = the owner's signals. Combinational mux selected by
//     registered owner_o; 0 added latency.
//   - m_ack_o = owner_o & {5{wbm_ack_i}}; m_err_o = owner_o & {5{wbm_err_i}}.
//   - Changes on gnt are ignored while in OWN; ownership is held until the owner drops cyc.
//   - Owner drops m_cyc_i -> go to IDLE and clear owner_o. The next grant is taken
//     in that IDLE cycle, so there is 1 dead cycle between owners.
//   - A late wbm_ack_i after cyc drops is not routed to any master.
//  Watchdog (TMO>0):
//   - Counts up while in OWN with wbm_stb_o=1 and !(ack|err).
//   - Clears to 0 on ack, err, stb=0, or leaving OWN.
//   - count==TMO-1 with no response -> next cycle: m_err_o[owner]=1 for exactly
//     one cycle, tmo_o=1, go to ABORT.
//   - Simultaneous ack and timeout in the same cycle: ack wins, count clears, no abort.
//  ABORT:
//   - wbm_cyc_o=wbm_stb_o=0; slave ack/err are discarded.
//   - Stays in ABORT until the owner drops m_cyc_i, then goes to IDLE.
//  Counter width = $clog2(TMO+1); the count saturates and never wraps.
// STRUCTURE
//  Shared package ss_wb_pkg holds NM=5, the FSM state localparams (IDLE/OWN/ABORT)
//  and a one-hot-to-index function.
//  One sub-module, wb_watchdog (count/clear/expire), is reused by other ss_adma stages.
//  The datapath mux stays inline as an AND-OR over owner_o.
// TESTING
//  1. Reset with all inputs 0 -> every output 0. Pulse wb_rst_i mid-OWN -> wbm_cyc_o
//     falls without waiting for a clock edge.
//  2. gnt=5'b00100, m_cyc_i[2]=1, adr=0x1000 -> next cycle owner_o=00100,
//     wbm_adr_o=0x1000. wbm_ack_i -> m_ack_o=00100 only.
//  3. Master 2 owns the bus; set gnt=00001 with m_cyc_i[0]=1 -> owner stays 00100
//     until m_cyc_i[2] drops. After 1 idle cycle, owner_o=00001.
//  4. gnt=5'b10010 (illegal multi-hot) with both cyc high -> owner_o=00010.
//  5. TMO=8, owner 3, stb held high with no ack -> after 8 cycles m_err_o=01000 and
//     tmo_o=1 for exactly 1 cycle, wbm_cyc_o=0. Owner drops cyc -> IDLE.
//  6. TMO=8, ack arrives in the expiry cycle -> m_ack_o asserted, no err, tmo_o=0.

Source files
------------

// File: rtl/ss_wb_pkg.sv
// Shared definitions for the ss_adma Wishbone master stages: master count,
// ownership FSM states and a helper that reduces a grant vector to an index.
package ss_wb_pkg;

    localparam int NM = 5;
    localparam int IW = $clog2(NM);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    // Multi-hot inputs resolve to the lowest set index so an illegal grant still picks one master.
    function automatic logic [IW-1:0] onehot_to_idx(input logic [NM-1:0] vec);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive unanswered strobe cycles and flags expiry
// in the cycle where the count reaches TMO-1. TMO=0 disables it.
module wb_watchdog #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic resp,
    output logic expire
);

    localparam int            CW   = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] LAST = (TMO > 0) ? CW'(TMO - 1) : '0;
    localparam logic [CW-1:0] MAX  = (TMO > 0) ? CW'(TMO) : '0;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (TMO == 0 || !active || resp) begin
            count_d = '0;
        end else begin
            expire = (count_q == LAST);
            if (count_q != MAX) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_master_mux.sv
// Wishbone master multiplexer: latches the arbiter grant into an ownership register,
// routes the owner onto the shared bus and aborts cycles whose slave never answers.
module wb_master_mux
    import ss_wb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NM-1:0]      gnt,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM*DW/8-1:0] m_sel_i,
    input  logic [NM*AW-1:0]   m_adr_i,
    input  logic [NM*DW-1:0]   m_dat_i,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [DW-1:0]      m_dat_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DW/8-1:0]    wbm_sel_o,
    output logic [AW-1:0]      wbm_adr_o,
    output logic [DW-1:0]      wbm_dat_o,
    input  logic [DW-1:0]      wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic [NM-1:0]      owner_o,
    output logic               tmo_o
);

    localparam int SW = DW / 8;

    state_e          state_q, state_d;
    logic [NM-1:0]   owner_q, owner_d;
    logic            tmo_q, tmo_d;
    logic [NM-1:0]   sel;
    logic            own_cyc, own_stb, own_we;
    logic [SW-1:0]   own_sel;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic            wd_expire;

    assign sel = gnt & m_cyc_i;

    // AND-OR datapath mux keyed by the registered owner; zero when nobody owns the bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int i = 0; i < NM; i++) begin
            own_cyc |= owner_q[i] & m_cyc_i[i];
            own_stb |= owner_q[i] & m_stb_i[i];
            own_we  |= owner_q[i] & m_we_i[i];
            own_sel |= {SW{owner_q[i]}} & m_sel_i[i*SW +: SW];
            own_adr |= {AW{owner_q[i]}} & m_adr_i[i*AW +: AW];
            own_dat |= {DW{owner_q[i]}} & m_dat_i[i*DW +: DW];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|sel) begin
                    state_d = ST_OWN;
                    owner_d = '0;
                    owner_d[onehot_to_idx(sel)] = 1'b1;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                    tmo_d   = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
    end

    // Responses are steered only while the owner's cycle is live on the bus, so late acks are dropped.
    always_comb begin
        wbm_cyc_o = (state_q == ST_OWN) & own_cyc;
        wbm_stb_o = wbm_cyc_o & own_stb;
        wbm_we_o  = own_we;
        wbm_sel_o = own_sel;
        wbm_adr_o = own_adr;
        wbm_dat_o = own_dat;
        m_dat_o   = wbm_dat_i;
        m_ack_o   = owner_q & {NM{wbm_ack_i & wbm_cyc_o}};
        m_err_o   = (owner_q & {NM{wbm_err_i & wbm_cyc_o}}) | (owner_q & {NM{tmo_q}});
        owner_o   = owner_q;
        tmo_o     = tmo_q;
    end

    wb_watchdog #(
        .TMO(TMO)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .active (wbm_stb_o),
        .resp   (wbm_ack_i | wbm_err_i),
        .expire (wd_expire)
    );

endmodule

// File: tb/tb_wb_master_mux.sv
// Testbench for wb_master_mux: directed scenarios followed by random traffic,
// all compared against a cycle-level ownership model.
module tb_wb_master_mux;

    localparam int NM  = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic               wb_clk_i = 1'b0;
    logic               wb_rst_i;
    logic [NM-1:0]      gnt;
    logic [NM-1:0]      m_cyc_i;
    logic [NM-1:0]      m_stb_i;
    logic [NM-1:0]      m_we_i;
    logic [NM*SW-1:0]   m_sel_i;
    logic [NM*AW-1:0]   m_adr_i;
    logic [NM*DW-1:0]   m_dat_i;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_err_o;
    logic [DW-1:0]      m_dat_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic               wbm_we_o;
    logic [SW-1:0]      wbm_sel_o;
    logic [AW-1:0]      wbm_adr_o;
    logic [DW-1:0]      wbm_dat_o;
    logic [DW-1:0]      wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic [NM-1:0]      owner_o;
    logic               tmo_o;

    int errors = 0;
    int checks = 0;

    // Reference model: owning master index (-1 = none), abort flag, stall length, pending abort pulse.
    int m_owner;
    bit m_abort;
    int m_stall;
    bit m_pulse;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_master_mux #(
        .AW  (AW),
        .DW  (DW),
        .TMO (TMO)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .gnt       (gnt),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .owner_o   (owner_o),
        .tmo_o     (tmo_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        m_owner = -1;
        m_abort = 1'b0;
        m_stall = 0;
        m_pulse = 1'b0;
    endtask

    // Compare every output against what the model predicts for the current cycle.
    task automatic checkModel();
        logic [NM-1:0] own_mask;
        logic          cyc_exp, stb_exp, we_exp;
        logic [SW-1:0] sel_exp;
        logic [AW-1:0] adr_exp;
        logic [DW-1:0] dat_exp;
        logic [NM-1:0] ack_exp, err_exp;
        own_mask = '0;
        cyc_exp  = 1'b0;
        stb_exp  = 1'b0;
        we_exp   = 1'b0;
        sel_exp  = '0;
        adr_exp  = '0;
        dat_exp  = '0;
        if (m_owner >= 0) begin
            own_mask[m_owner] = 1'b1;
            we_exp  = m_we_i[m_owner];
            sel_exp = m_sel_i[m_owner*SW +: SW];
            adr_exp = m_adr_i[m_owner*AW +: AW];
            dat_exp = m_dat_i[m_owner*DW +: DW];
            cyc_exp = !m_abort && m_cyc_i[m_owner];
            stb_exp = cyc_exp && m_stb_i[m_owner];
        end
        ack_exp = (cyc_exp && wbm_ack_i) ? own_mask : '0;
        err_exp = ((cyc_exp && wbm_err_i) || m_pulse) ? own_mask : '0;
        checkOutput("owner", 64'(owner_o), 64'(own_mask));
        checkOutput("cyc", 64'(wbm_cyc_o), 64'(cyc_exp));
        checkOutput("stb", 64'(wbm_stb_o), 64'(stb_exp));
        checkOutput("we", 64'(wbm_we_o), 64'(we_exp));
        checkOutput("sel", 64'(wbm_sel_o), 64'(sel_exp));
        checkOutput("adr", 64'(wbm_adr_o), 64'(adr_exp));
        checkOutput("wdat", 64'(wbm_dat_o), 64'(dat_exp));
        checkOutput("rdat", 64'(m_dat_o), 64'(wbm_dat_i));
        checkOutput("ack", 64'(m_ack_o), 64'(ack_exp));
        checkOutput("err", 64'(m_err_o), 64'(err_exp));
        checkOutput("tmo", 64'(tmo_o), 64'(m_pulse));
    endtask

    // Advance the model across one clock edge using the inputs that were present before it.
    task automatic modelEdge();
        bit pulse;
        pulse = 1'b0;
        if (m_owner < 0) begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (gnt[i] && m_cyc_i[i]) m_owner = i;
            end
            m_stall = 0;
            m_abort = 1'b0;
        end else if (!m_cyc_i[m_owner]) begin
            m_owner = -1;
            m_abort = 1'b0;
            m_stall = 0;
        end else if (!m_abort) begin
            if (m_stb_i[m_owner] && !(wbm_ack_i || wbm_err_i)) begin
                if (m_stall == TMO - 1) begin
                    m_abort = 1'b1;
                    pulse   = 1'b1;
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
            end else begin
                m_stall = 0;
            end
        end
        m_pulse = pulse;
    endtask

    task automatic sample();
        @(negedge wb_clk_i);
        checkModel();
    endtask

    task automatic advance();
        @(posedge wb_clk_i);
        modelEdge();
        #1;
    endtask

    task automatic clearAll();
        gnt       = '0;
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_sel_i   = '0;
        m_adr_i   = '0;
        m_dat_i   = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
    endtask

    task automatic setMaster(input int i, input bit cyc, input bit stb, input bit we, input logic [AW-1:0] adr);
        m_cyc_i[i]           = cyc;
        m_stb_i[i]           = stb;
        m_we_i[i]            = we;
        m_adr_i[i*AW +: AW]  = adr;
        m_sel_i[i*SW +: SW]  = '1;
        m_dat_i[i*DW +: DW]  = DW'(32'hA5A5_0000 + i);
    endtask

    task automatic applyStimulus();
        int g;
        for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 7) == 0) m_cyc_i[i] = ~m_cyc_i[i];
            m_stb_i[i]          = m_cyc_i[i] && ($urandom_range(0, 15) != 0);
            m_we_i[i]           = 1'($urandom_range(0, 1));
            m_sel_i[i*SW +: SW] = SW'($urandom);
            m_adr_i[i*AW +: AW] = AW'($urandom);
            m_dat_i[i*DW +: DW] = DW'($urandom);
        end
        g = $urandom_range(0, 9);
        if (g < NM) begin
            gnt    = '0;
            gnt[g] = 1'b1;
        end else if (g == NM) begin
            gnt = '0;
        end else begin
            gnt = NM'($urandom);
        end
        wbm_ack_i = ($urandom_range(0, 11) == 0);
        wbm_err_i = ($urandom_range(0, 29) == 0);
        wbm_dat_i = DW'($urandom);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        clearAll();
        resetModel();

        #12;
        checkOutput("rst_owner", 64'(owner_o), 64'h0);
        checkOutput("rst_cyc", 64'(wbm_cyc_o), 64'h0);
        checkOutput("rst_stb", 64'(wbm_stb_o), 64'h0);
        checkOutput("rst_adr", 64'(wbm_adr_o), 64'h0);
        checkOutput("rst_ack", 64'(m_ack_o), 64'h0);
        checkOutput("rst_err", 64'(m_err_o), 64'h0);
        checkOutput("rst_tmo", 64'(tmo_o), 64'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        advance();

        // Single master takes the bus one cycle after the grant and receives its ack.
        gnt = 5'b00100;
        setMaster(2, 1'b1, 1'b1, 1'b0, 32'h1000);
        sample();
        checkOutput("t2_latency", 64'(wbm_cyc_o), 64'h0);
        advance();
        sample();
        checkOutput("t2_owner", 64'(owner_o), 64'h04);
        checkOutput("t2_adr", 64'(wbm_adr_o), 64'h1000);
        advance();
        wbm_ack_i = 1'b1;
        sample();
        checkOutput("t2_ack", 64'(m_ack_o), 64'h04);
        advance();
        wbm_ack_i = 1'b0;

        // Grant change is ignored until the owner releases; one dead cycle between owners.
        gnt = 5'b00001;
        setMaster(0, 1'b1, 1'b1, 1'b1, 32'h2000);
        repeat (2) begin
            sample();
            checkOutput("t3_hold", 64'(owner_o), 64'h04);
            advance();
        end
        m_cyc_i[2] = 1'b0;
        m_stb_i[2] = 1'b0;
        sample();
        advance();
        sample();
        checkOutput("t3_dead", 64'(owner_o), 64'h0);
        advance();
        sample();
        checkOutput("t3_next", 64'(owner_o), 64'h01);
        checkOutput("t3_adr", 64'(wbm_adr_o), 64'h2000);
        advance();

        // Multi-hot grant resolves to the lowest index.
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        gnt = 5'b10010;
        setMaster(1, 1'b1, 1'b1, 1'b0, 32'h3000);
        setMaster(4, 1'b1, 1'b1, 1'b0, 32'h4000);
        sample();
        advance();
        sample();
        checkOutput("t4_dead", 64'(owner_o), 64'h0);
        advance();
        sample();
        checkOutput("t4_owner", 64'(owner_o), 64'h02);
        checkOutput("t4_adr", 64'(wbm_adr_o), 64'h3000);

        // Asynchronous reset in the middle of an owned cycle.
        #2 wb_rst_i = 1'b1;
        #1;
        checkOutput("rst_async_cyc", 64'(wbm_cyc_o), 64'h0);
        checkOutput("rst_async_owner", 64'(owner_o), 64'h0);
        resetModel();
        #1 wb_rst_i = 1'b0;
        clearAll();
        advance();

        // Watchdog expiry: error pulse on the owner, tmo for one cycle, bus released.
        gnt = 5'b01000;
        setMaster(3, 1'b1, 1'b1, 1'b1, 32'h5000);
        sample();
        advance();
        for (int k = 0; k < TMO; k++) begin
            sample();
            checkOutput("t5_no_tmo", 64'(tmo_o), 64'h0);
            checkOutput("t5_cyc_held", 64'(wbm_cyc_o), 64'h1);
            advance();
        end
        sample();
        checkOutput("t5_tmo", 64'(tmo_o), 64'h1);
        checkOutput("t5_err", 64'(m_err_o), 64'h08);
        checkOutput("t5_cyc_drop", 64'(wbm_cyc_o), 64'h0);
        advance();
        sample();
        checkOutput("t5_tmo_once", 64'(tmo_o), 64'h0);
        checkOutput("t5_err_once", 64'(m_err_o), 64'h0);
        advance();
        m_cyc_i[3] = 1'b0;
        m_stb_i[3] = 1'b0;
        gnt = '0;
        sample();
        advance();
        sample();
        checkOutput("t5_idle", 64'(owner_o), 64'h0);
        advance();

        // Ack arriving in the expiry cycle wins over the timeout.
        gnt = 5'b01000;
        m_cyc_i[3] = 1'b1;
        m_stb_i[3] = 1'b1;
        sample();
        advance();
        repeat (TMO - 1) begin
            sample();
            advance();
        end
        wbm_ack_i = 1'b1;
        sample();
        checkOutput("t6_ack", 64'(m_ack_o), 64'h08);
        checkOutput("t6_no_err", 64'(m_err_o), 64'h0);
        checkOutput("t6_no_tmo", 64'(tmo_o), 64'h0);
        advance();
        wbm_ack_i = 1'b0;
        sample();
        checkOutput("t6_after_tmo", 64'(tmo_o), 64'h0);
        checkOutput("t6_after_cyc", 64'(wbm_cyc_o), 64'h1);
        advance();
        clearAll();
        sample();
        advance();

        // Random traffic against the model.
        repeat (600) begin
            applyStimulus();
            sample();
            advance();
        end
        clearAll();
        repeat (3) begin
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
